// File: rtl/gpr_wb_arbiter.sv
// Register-file write-side controller: round-robin merge of ALU and LSU writebacks onto
// one registered write port, plus a per-register busy scoreboard for RAW/WAW hazards.
module gpr_wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    output logic                  issue_ready,
    input  logic                  alu_valid,
    input  logic [ADDR_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    output logic                  alu_ready,
    input  logic                  lsu_valid,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    output logic                  lsu_ready,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_rd,
    output logic [DATA_WIDTH-1:0] rf_data,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  wb_err
);

    localparam int NUM_REGS = 1 << ADDR_WIDTH;

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_LSU = 1'b1
    } grant_e;

    grant_e                last_grant_q, last_grant_d;
    logic [NUM_REGS-1:0]   busy_q, busy_d;
    logic                  rf_wen_q, rf_wen_d;
    logic [ADDR_WIDTH-1:0] rf_rd_q, rf_rd_d;
    logic [DATA_WIDTH-1:0] rf_data_q, rf_data_d;
    logic                  wb_err_q, wb_err_d;

    logic                  grant_lsu;
    logic                  xfer;
    logic                  issue_fire;
    logic [ADDR_WIDTH-1:0] wb_rd;
    logic [DATA_WIDTH-1:0] wb_data;

    // With both sources pending, the one that did not win the last transfer goes first.
    always_comb begin
        grant_lsu = 1'b0;
        if (alu_valid && lsu_valid) begin
            grant_lsu = (last_grant_q == GRANT_ALU);
        end else begin
            grant_lsu = lsu_valid;
        end
    end

    assign alu_ready  = alu_valid && !grant_lsu;
    assign lsu_ready  = lsu_valid && grant_lsu;
    assign xfer       = alu_ready || lsu_ready;
    assign wb_rd      = grant_lsu ? lsu_rd : alu_rd;
    assign wb_data    = grant_lsu ? lsu_data : alu_data;

    assign issue_ready = (issue_rd == '0) || !busy_q[issue_rd];
    assign issue_fire  = issue_valid && issue_ready && (issue_rd != '0);

    assign rs1_busy = (rs1 != '0) && busy_q[rs1];
    assign rs2_busy = (rs2 != '0) && busy_q[rs2];

    always_comb begin
        busy_d       = busy_q;
        last_grant_d = last_grant_q;
        rf_wen_d     = xfer && (wb_rd != '0);
        rf_rd_d      = rf_rd_q;
        rf_data_d    = rf_data_q;
        wb_err_d     = wb_err_q;

        // Busy clears as the file is written, not at acceptance, so decode never sees stale data.
        if (rf_wen_q) begin
            busy_d[rf_rd_q] = 1'b0;
        end
        if (issue_fire) begin
            busy_d[issue_rd] = 1'b1;
        end

        if (xfer) begin
            last_grant_d = grant_lsu ? GRANT_LSU : GRANT_ALU;
            rf_rd_d      = wb_rd;
            rf_data_d    = wb_data;
            if ((wb_rd != '0) && !busy_q[wb_rd]) begin
                wb_err_d = 1'b1;
            end
        end

        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= GRANT_ALU;
            busy_q       <= '0;
            rf_wen_q     <= 1'b0;
            rf_rd_q      <= '0;
            rf_data_q    <= '0;
            wb_err_q     <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            busy_q       <= busy_d;
            rf_wen_q     <= rf_wen_d;
            rf_rd_q      <= rf_rd_d;
            rf_data_q    <= rf_data_d;
            wb_err_q     <= wb_err_d;
        end
    end

    assign rf_wen  = rf_wen_q;
    assign rf_rd   = rf_rd_q;
    assign rf_data = rf_data_q;
    assign wb_err  = wb_err_q;

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Scoreboard bench for gpr_wb_arbiter: directed scenarios then randomized traffic, checked
// against a register-level reference model of grants, busy bits and the write port.
module tb_gpr_wb_arbiter;

    localparam int AW = 5;
    localparam int DW = 64;
    localparam int NR = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          issue_valid = 1'b0;
    logic [AW-1:0] issue_rd = '0;
    logic          issue_ready;
    logic          alu_valid = 1'b0;
    logic [AW-1:0] alu_rd = '0;
    logic [DW-1:0] alu_data = '0;
    logic          alu_ready;
    logic          lsu_valid = 1'b0;
    logic [AW-1:0] lsu_rd = '0;
    logic [DW-1:0] lsu_data = '0;
    logic          lsu_ready;
    logic          rf_wen;
    logic [AW-1:0] rf_rd;
    logic [DW-1:0] rf_data;
    logic [AW-1:0] rs1 = '0;
    logic [AW-1:0] rs2 = '0;
    logic          rs1_busy;
    logic          rs2_busy;
    logic          wb_err;

    gpr_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_data(rf_data),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit            wen;
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
        bit            err;
    } exp_t;

    exp_t exp_q[$];
    bit   mon_en = 1'b0;

    // Reference model: which register holds an outstanding write, who won last, sticky error,
    // and the write accepted last cycle that lands in the file on the coming edge.
    bit            m_busy[NR];
    bit            m_last_lsu;
    bit            m_err;
    bit            m_pend_wen;
    logic [AW-1:0] m_pend_rd;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_last_lsu = 1'b0;
        m_err      = 1'b0;
        m_pend_wen = 1'b0;
        m_pend_rd  = '0;
        exp_q.delete();
    endtask

    task automatic idle_inputs();
        issue_valid = 1'b0;
        alu_valid   = 1'b0;
        lsu_valid   = 1'b0;
    endtask

    // Called right after a negedge with inputs already applied; advances one clock.
    task automatic cycle(output bit ga, output bit gl);
        logic [AW-1:0] rd;
        logic [DW-1:0] d;
        bit            acc, ir;
        exp_t          e;
        #1;
        if (alu_valid && lsu_valid) begin
            gl = !m_last_lsu;
            ga = m_last_lsu;
        end else begin
            ga = alu_valid;
            gl = lsu_valid;
        end
        ir = (issue_rd == 0) || !m_busy[issue_rd];
        chk("alu_ready", alu_ready, ga);
        chk("lsu_ready", lsu_ready, gl);
        chk("issue_ready", issue_ready, ir);
        chk("rs1_busy", rs1_busy, m_busy[rs1]);
        chk("rs2_busy", rs2_busy, m_busy[rs2]);

        acc = ga || gl;
        rd  = gl ? lsu_rd : alu_rd;
        d   = gl ? lsu_data : alu_data;
        if (acc && rd != 0 && !m_busy[rd]) m_err = 1'b1;
        if (acc) m_last_lsu = gl;
        if (m_pend_wen) m_busy[m_pend_rd] = 1'b0;
        if (issue_valid && ir && issue_rd != 0) m_busy[issue_rd] = 1'b1;
        m_pend_wen = acc && (rd != 0);
        m_pend_rd  = rd;

        e.wen  = m_pend_wen;
        e.rd   = rd;
        e.data = d;
        e.err  = m_err;
        exp_q.push_back(e);
        mon_en = 1'b1;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_empty actual=rf_wen:%0b expected=queued_entry", rf_wen);
            end else begin
                e = exp_q.pop_front();
                chk("rf_wen", rf_wen, e.wen);
                if (e.wen) begin
                    chk("rf_rd", rf_rd, e.rd);
                    chk("rf_data", rf_data, e.data);
                end
                chk("wb_err", wb_err, e.err);
            end
        end
    end

    task automatic do_reset();
        mon_en = 1'b0;
        rst_n  = 1'b0;
        idle_inputs();
        model_clear();
        repeat (2) @(negedge clk);
        chk("reset_rf_wen", rf_wen, 0);
        chk("reset_rf_rd", rf_rd, 0);
        chk("reset_rf_data", rf_data, 0);
        chk("reset_wb_err", wb_err, 0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic issue(input int r);
        bit ga, gl;
        issue_valid = 1'b1;
        issue_rd    = AW'(r);
        cycle(ga, gl);
        issue_valid = 1'b0;
    endtask

    function automatic logic [AW-1:0] pick_rd();
        for (int t = 0; t < 6; t++) begin
            int r;
            r = int'($urandom_range(1, NR - 1));
            if (m_busy[r]) return AW'(r);
        end
        return AW'($urandom_range(0, NR - 1));
    endfunction

    initial begin
        bit ga, gl;
        int ai, li;
        int alu_list[3];
        int lsu_list[3];
        alu_list = '{10, 12, 14};
        lsu_list = '{11, 13, 15};

        do_reset();

        // Issue 5, ALU writeback of 5, busy visible then cleared after the file write.
        issue(5);
        rs1 = 5;
        cycle(ga, gl);
        alu_valid = 1'b1; alu_rd = 5; alu_data = 64'hAB;
        cycle(ga, gl);
        alu_valid = 1'b0;
        repeat (2) cycle(ga, gl);

        // Simultaneous ALU/LSU: LSU first, ALU next cycle.
        issue(3);
        issue(4);
        alu_valid = 1'b1; alu_rd = 3; alu_data = 64'h3333;
        lsu_valid = 1'b1; lsu_rd = 4; lsu_data = 64'h4444;
        cycle(ga, gl);
        if (gl) lsu_valid = 1'b0;
        if (ga) alu_valid = 1'b0;
        cycle(ga, gl);
        idle_inputs();
        repeat (2) cycle(ga, gl);

        // Six back-to-back cycles with both sources valid.
        for (int r = 10; r <= 15; r++) issue(r);
        ai = 0; li = 0;
        alu_valid = 1'b1; alu_rd = AW'(alu_list[0]); alu_data = 64'hA0;
        lsu_valid = 1'b1; lsu_rd = AW'(lsu_list[0]); lsu_data = 64'hB0;
        for (int n = 0; n < 6; n++) begin
            cycle(ga, gl);
            if (ga) begin
                ai++;
                alu_rd = AW'(alu_list[ai % 3]); alu_data = 64'hA0 + DW'(ai);
            end
            if (gl) begin
                li++;
                lsu_rd = AW'(lsu_list[li % 3]); lsu_data = 64'hB0 + DW'(li);
            end
        end
        idle_inputs();
        repeat (2) cycle(ga, gl);

        // WAW stall on x7 until its writeback lands.
        issue(7);
        issue_valid = 1'b1; issue_rd = 7;
        cycle(ga, gl);
        alu_valid = 1'b1; alu_rd = 7; alu_data = 64'h77;
        cycle(ga, gl);
        alu_valid = 1'b0;
        cycle(ga, gl);
        cycle(ga, gl);
        issue_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 7; alu_data = 64'h78;
        cycle(ga, gl);
        alu_valid = 1'b0;
        repeat (2) cycle(ga, gl);

        // x0 writeback is swallowed; then a stray write to x9 raises the sticky error.
        lsu_valid = 1'b1; lsu_rd = 0; lsu_data = 64'hDEAD;
        cycle(ga, gl);
        lsu_valid = 1'b0;
        cycle(ga, gl);
        alu_valid = 1'b1; alu_rd = 9; alu_data = 64'h99;
        cycle(ga, gl);
        alu_valid = 1'b0;
        repeat (3) cycle(ga, gl);

        // Asynchronous reset in the middle of a cycle with a write in flight.
        issue(20);
        issue(21);
        rs1 = 20; rs2 = 21;
        alu_valid = 1'b1; alu_rd = 20; alu_data = 64'h2020;
        cycle(ga, gl);
        alu_valid = 1'b0;
        #3;
        chk("pre_reset_rf_wen", rf_wen, 1);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("async_rf_wen", rf_wen, 0);
        chk("async_rf_rd", rf_rd, 0);
        chk("async_rf_data", rf_data, 0);
        chk("async_wb_err", wb_err, 0);
        chk("async_rs1_busy", rs1_busy, 0);
        chk("async_rs2_busy", rs2_busy, 0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) cycle(ga, gl);

        // Randomized traffic honouring the hold-while-stalled rule.
        do_reset();
        ga = 1'b0; gl = 1'b0;
        for (int n = 0; n < 500; n++) begin
            if (!alu_valid || ga) begin
                alu_valid = ($urandom_range(0, 9) < 6);
                alu_rd    = pick_rd();
                alu_data  = {$urandom, $urandom};
            end
            if (!lsu_valid || gl) begin
                lsu_valid = ($urandom_range(0, 9) < 6);
                lsu_rd    = pick_rd();
                lsu_data  = {$urandom, $urandom};
            end
            issue_valid = ($urandom_range(0, 1) == 1);
            issue_rd    = AW'($urandom_range(0, NR - 1));
            rs1         = AW'($urandom_range(0, NR - 1));
            rs2         = AW'($urandom_range(0, NR - 1));
            cycle(ga, gl);
        end
        idle_inputs();
        repeat (3) cycle(ga, gl);
        mon_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
